// File: rtl/high_score_table_if.sv
// Bus between the game FSM / menu logic and the high-score table:
// game-end capture inputs, table read port and attempt status.
interface high_score_table_if #(
  parameter int SCORE_W = 8,
  parameter int DEPTH   = 4
);
  localparam int RANK_W = $clog2(DEPTH + 1);
  localparam int IDX_W  = $clog2(DEPTH);

  logic [2:0]         mode;
  logic [SCORE_W-1:0] score;
  logic               clear;
  logic [IDX_W-1:0]   rd_idx;
  logic [SCORE_W-1:0] rd_score;
  logic               rd_valid;
  logic [SCORE_W-1:0] highest_score;
  logic               busy;
  logic               done;
  logic [RANK_W-1:0]  rank;
  logic               new_record;

  modport master (
    output mode, score, clear, rd_idx,
    input  rd_score, rd_valid, highest_score, busy, done, rank, new_record
  );

  modport slave (
    input  mode, score, clear, rd_idx,
    output rd_score, rd_valid, highest_score, busy, done, rank, new_record
  );
endinterface

// File: rtl/high_score_table.sv
// Top-N sorted leaderboard: on game end, scans for the score's rank then inserts it.
// Optional macro HS_TIE_NEWER_FIRST_EN: a new equal score ranks above an older one.
module high_score_table #(
  parameter int         SCORE_W     = 8,
  parameter int         DEPTH       = 4,
  parameter logic [2:0] FINISH_MODE = 3'b101
) (
  input logic              clk,
  input logic              rst,
  high_score_table_if.slave bus
);
  localparam int RANK_W = $clog2(DEPTH + 1);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [RANK_W-1:0] NONE = RANK_W'(DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SCAN   = 2'd1;
  localparam logic [1:0] INSERT = 2'd2;

  logic [1:0]         state;
  logic [2:0]         mode_q;
  logic [SCORE_W-1:0] cand;
  logic [IDX_W-1:0]   idx;
  logic [RANK_W-1:0]  pos;
  logic [RANK_W-1:0]  rank;
  logic               done;
  logic               new_record;
  logic [SCORE_W-1:0] entry_score [DEPTH];
  logic               entry_valid [DEPTH];
  logic               start;

  function automatic logic beats(input logic [SCORE_W-1:0] c,
                                 input logic [SCORE_W-1:0] e,
                                 input logic               v);
`ifdef HS_TIE_NEWER_FIRST_EN
    return !v || (c >= e);
`else
    return !v || (c > e);
`endif
  endfunction

  assign start = (bus.mode == FINISH_MODE) && (mode_q != FINISH_MODE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= '0;
      state      <= IDLE;
      cand       <= '0;
      idx        <= '0;
      pos        <= NONE;
      rank       <= NONE;
      done       <= 1'b0;
      new_record <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_score[i] <= '0;
        entry_valid[i] <= 1'b0;
      end
    end else begin
      mode_q     <= bus.mode;
      done       <= 1'b0;
      new_record <= 1'b0;
      if (bus.clear) begin
        // Wipe aborts any in-flight attempt silently and swallows a same-edge start.
        state <= IDLE;
        rank  <= NONE;
        for (int i = 0; i < DEPTH; i++) begin
          entry_score[i] <= '0;
          entry_valid[i] <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              cand  <= bus.score;
              idx   <= '0;
              pos   <= NONE;
              state <= SCAN;
            end
          end
          SCAN: begin
            if (pos == NONE && beats(cand, entry_score[idx], entry_valid[idx]))
              pos <= RANK_W'(idx);
            if (idx == IDX_W'(DEPTH - 1))
              state <= INSERT;
            else
              idx <= idx + IDX_W'(1);
          end
          INSERT: begin
            if (pos < NONE) begin
              for (int i = 1; i < DEPTH; i++) begin
                if (RANK_W'(i) > pos) begin
                  entry_score[i] <= entry_score[i-1];
                  entry_valid[i] <= entry_valid[i-1];
                end
              end
              for (int i = 0; i < DEPTH; i++) begin
                if (RANK_W'(i) == pos) begin
                  entry_score[i] <= cand;
                  entry_valid[i] <= 1'b1;
                end
              end
            end
            rank       <= pos;
            done       <= 1'b1;
            new_record <= (pos == '0);
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Invalid entries always hold score 0, so entry 0 can be exported directly.
  always_comb begin
    bus.rd_score = '0;
    bus.rd_valid = 1'b0;
    if (int'(bus.rd_idx) < DEPTH) begin
      bus.rd_valid = entry_valid[bus.rd_idx];
      bus.rd_score = entry_valid[bus.rd_idx] ? entry_score[bus.rd_idx] : '0;
    end
  end

  assign bus.highest_score = entry_valid[0] ? entry_score[0] : '0;
  assign bus.busy          = (state != IDLE);
  assign bus.done          = done;
  assign bus.rank          = rank;
  assign bus.new_record    = new_record;
endmodule

// File: tb/tb_high_score_table.sv
// Directed bench for high_score_table with DEPTH=4, SCORE_W=8.
module tb_high_score_table;
  localparam logic [2:0] FIN = 3'b101;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  high_score_table_if #(.SCORE_W(8), .DEPTH(4)) bus ();

  high_score_table #(.SCORE_W(8), .DEPTH(4), .FINISH_MODE(3'b101)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reads all four entries; entry i lands in sc[8*i +: 8] and vl[i]. Takes 4 time units.
  task automatic read_table(output logic [31:0] sc, output logic [3:0] vl);
    for (int i = 0; i < 4; i++) begin
      bus.rd_idx = 2'(i);
      #1;
      sc[8*i +: 8] = bus.rd_score;
      vl[i]        = bus.rd_valid;
    end
  endtask

  // Plays one game; lat = edges from start edge to done (-1 if done never came).
  task automatic run_game(input logic [7:0] s, output int lat, output int busy_n,
                          output logic [2:0] rk, output logic nr);
    bus.score = s;
    bus.mode  = FIN;
    lat = -1; busy_n = 0; rk = 3'bxxx; nr = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (bus.busy) busy_n++;
      if (bus.done) begin
        lat = n - 1;
        rk  = bus.rank;
        nr  = bus.new_record;
        break;
      end
    end
    bus.mode = 3'b000;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] sc;
    logic [3:0]  vl;
    #2 rst = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else passed++;
    total++; if (bus.rank !== 3'd4) $display("FAIL reset_rank: got %0d expected 4", bus.rank); else passed++;
    total++; if (bus.highest_score !== 8'd0) $display("FAIL reset_highest: got %0d expected 0", bus.highest_score); else passed++;
    total++; if (bus.done !== 1'b0 || bus.new_record !== 1'b0)
      $display("FAIL reset_pulses: got done=%b nr=%b expected 0 0", bus.done, bus.new_record); else passed++;
    read_table(sc, vl);
    total++; if (vl !== 4'b0000) $display("FAIL reset_valid: got %b expected 0000", vl); else passed++;
    #10 rst = 1'b0;
    tick();
  endtask

  task automatic test_first_fill();
    int lat, bn; logic [2:0] rk; logic nr;
    logic [31:0] sc; logic [3:0] vl;
    run_game(8'd0, lat, bn, rk, nr);
    total++; if (lat !== 5) $display("FAIL fill_latency: got %0d expected 5", lat); else passed++;
    total++; if (bn !== 5) $display("FAIL fill_busy_cycles: got %0d expected 5", bn); else passed++;
    total++; if (rk !== 3'd0 || nr !== 1'b1) $display("FAIL fill_rank: got rank=%0d nr=%b expected 0 1", rk, nr); else passed++;
    total++; if (bus.done !== 1'b0) $display("FAIL fill_done_width: got %b expected 0", bus.done); else passed++;
    read_table(sc, vl);
    total++; if (vl !== 4'b0001 || sc !== 32'd0)
      $display("FAIL fill_table: got v=%b s=%h expected 0001 00000000", vl, sc); else passed++;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    read_table(sc, vl);
    total++; if (vl !== 4'b0000 || bus.rank !== 3'd4)
      $display("FAIL clear_idle: got v=%b rank=%0d expected 0000 4", vl, bus.rank); else passed++;
    tick();
  endtask

  task automatic test_sorted_insert();
    int lat, bn; logic [2:0] rk; logic nr;
    logic [31:0] sc; logic [3:0] vl;
    logic [7:0] sv [4] = '{8'd50, 8'd90, 8'd70, 8'd10};
    logic [2:0] er [4] = '{3'd0, 3'd0, 3'd1, 3'd3};
    logic       en [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int g = 0; g < 4; g++) begin
      run_game(sv[g], lat, bn, rk, nr);
      total++; if (rk !== er[g] || nr !== en[g])
        $display("FAIL sorted_game%0d: got rank=%0d nr=%b expected %0d %b", g, rk, nr, er[g], en[g]); else passed++;
    end
    read_table(sc, vl);
    total++; if (vl !== 4'b1111 || sc !== {8'd10, 8'd50, 8'd70, 8'd90})
      $display("FAIL sorted_table: got v=%b s=%h expected 1111 0a32465a", vl, sc); else passed++;
    tick();
    run_game(8'd60, lat, bn, rk, nr);
    total++; if (rk !== 3'd2 || nr !== 1'b0) $display("FAIL insert60: got rank=%0d nr=%b expected 2 0", rk, nr); else passed++;
    read_table(sc, vl);
    total++; if (sc !== {8'd50, 8'd60, 8'd70, 8'd90})
      $display("FAIL insert60_table: got %h expected 323c465a", sc); else passed++;
    total++; if (bus.highest_score !== 8'd90) $display("FAIL highest90: got %0d expected 90", bus.highest_score); else passed++;
    tick();
  endtask

  task automatic test_not_placed();
    int lat, bn; logic [2:0] rk; logic nr;
    logic [31:0] sc; logic [3:0] vl;
    logic [2:0] exp_rk;
`ifdef HS_TIE_NEWER_FIRST_EN
    exp_rk = 3'd3;
`else
    exp_rk = 3'd4;
`endif
    run_game(8'd50, lat, bn, rk, nr);
    total++; if (rk !== exp_rk || nr !== 1'b0)
      $display("FAIL tie50: got rank=%0d nr=%b expected %0d 0", rk, nr, exp_rk); else passed++;
    read_table(sc, vl);
    total++; if (vl !== 4'b1111 || sc !== {8'd50, 8'd60, 8'd70, 8'd90})
      $display("FAIL tie50_table: got v=%b s=%h expected 1111 323c465a", vl, sc); else passed++;
    tick();
    run_game(8'd255, lat, bn, rk, nr);
    total++; if (rk !== 3'd0 || nr !== 1'b1) $display("FAIL max255: got rank=%0d nr=%b expected 0 1", rk, nr); else passed++;
    total++; if (bus.highest_score !== 8'd255) $display("FAIL highest255: got %0d expected 255", bus.highest_score); else passed++;
    read_table(sc, vl);
    total++; if (sc !== {8'd60, 8'd70, 8'd90, 8'd255})
      $display("FAIL max255_table: got %h expected 3c465aff", sc); else passed++;
    tick();
  endtask

  task automatic test_retrigger();
    int dones;
    logic [31:0] sc; logic [3:0] vl;
    // Hold FINISH for a long time: only the entering edge starts an attempt.
    bus.score = 8'd100;
    bus.mode  = FIN;
    dones = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (bus.done) dones++;
    end
    total++; if (dones !== 1) $display("FAIL hold_dones: got %0d expected 1", dones); else passed++;
    total++; if (bus.rank !== 3'd1) $display("FAIL hold_rank: got %0d expected 1", bus.rank); else passed++;
    bus.mode = 3'b000;
    tick();
    // Leave and re-enter FINISH while busy: second start must be dropped.
    bus.score = 8'd200;
    bus.mode  = FIN;
    dones = 0;
    tick();
    bus.mode = 3'b000;
    tick();
    bus.score = 8'd5;
    bus.mode  = FIN;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (bus.done) dones++;
    end
    bus.mode = 3'b000;
    tick();
    total++; if (dones !== 1) $display("FAIL busy_retrig_dones: got %0d expected 1", dones); else passed++;
    total++; if (bus.rank !== 3'd1) $display("FAIL busy_retrig_rank: got %0d expected 1", bus.rank); else passed++;
    read_table(sc, vl);
    total++; if (sc !== {8'd90, 8'd100, 8'd200, 8'd255})
      $display("FAIL retrig_table: got %h expected 5a64c8ff", sc); else passed++;
    tick();
  endtask

  task automatic test_abort_clear();
    int dones;
    logic [31:0] sc; logic [3:0] vl;
    bus.score = 8'd77;
    bus.mode  = FIN;
    tick();
    bus.mode = 3'b000;
    tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    total++; if (bus.busy !== 1'b0) $display("FAIL clear_abort_busy: got %b expected 0", bus.busy); else passed++;
    total++; if (bus.rank !== 3'd4) $display("FAIL clear_abort_rank: got %0d expected 4", bus.rank); else passed++;
    read_table(sc, vl);
    total++; if (vl !== 4'b0000 || sc !== 32'd0)
      $display("FAIL clear_abort_table: got v=%b s=%h expected 0000 00000000", vl, sc); else passed++;
    dones = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (bus.done) dones++;
    end
    total++; if (dones !== 0) $display("FAIL clear_abort_done: got %0d expected 0", dones); else passed++;
  endtask

  task automatic test_abort_rst();
    int lat, bn, dones; logic [2:0] rk; logic nr;
    logic [31:0] sc; logic [3:0] vl;
    run_game(8'd33, lat, bn, rk, nr);
    total++; if (rk !== 3'd0 || bus.highest_score !== 8'd33)
      $display("FAIL pre_rst_game: got rank=%0d hs=%0d expected 0 33", rk, bus.highest_score); else passed++;
    bus.score = 8'd44;
    bus.mode  = FIN;
    tick();
    bus.mode = 3'b000;
    tick();
    #2 rst = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.rank !== 3'd4 || bus.highest_score !== 8'd0)
      $display("FAIL rst_abort_outputs: got busy=%b rank=%0d hs=%0d expected 0 4 0", bus.busy, bus.rank, bus.highest_score);
    else passed++;
    read_table(sc, vl);
    total++; if (vl !== 4'b0000) $display("FAIL rst_abort_table: got %b expected 0000", vl); else passed++;
    rst = 1'b0;
    dones = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (bus.done) dones++;
    end
    total++; if (dones !== 0) $display("FAIL rst_abort_done: got %0d expected 0", dones); else passed++;
    run_game(8'd12, lat, bn, rk, nr);
    total++; if (lat !== 5 || rk !== 3'd0 || nr !== 1'b1)
      $display("FAIL post_rst_game: got lat=%0d rank=%0d nr=%b expected 5 0 1", lat, rk, nr); else passed++;
  endtask

  initial begin
    bus.mode   = 3'b000;
    bus.score  = 8'd0;
    bus.clear  = 1'b0;
    bus.rd_idx = 2'd0;
    test_reset();
    test_first_fill();
    test_sorted_insert();
    test_not_placed();
    test_retrigger();
    test_abort_clear();
    test_abort_rst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/high_score_table.md
# high_score_table

Parametrised top-N leaderboard that succeeds the single-register high-score check. When the game mode enters FINISH, the block captures the final score and runs a fixed-length scan to find the score's rank. It then inserts the score into a sorted table of DEPTH entries, shifting lower entries down. The block sits between the game-state FSM (mode, score) and the display/menu logic, which reads entries through a combinational read port.

## Interface
- SCORE_W, default 8: score width in bits.
- DEPTH, default 4: number of table entries, ≥2; entry 0 is highest.
- FINISH_MODE, default 3'b101: mode encoding that ends a game.
- RANK_W, default $clog2(DEPTH+1): width of rank output (derived, not overridden).

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high; forces all state to reset values immediately.
- mode  in  3  game mode from game FSM.
- score  in  SCORE_W  final score, sampled on the start edge.
- clear  in  1  synchronous table wipe.
- rd_idx  in  $clog2(DEPTH)  read address.
- rd_score  out  SCORE_W  score of entry rd_idx, combinational; 0 if the entry is invalid.
- rd_valid  out  1  valid bit of entry rd_idx, combinational.
- highest_score  out  SCORE_W  score of entry 0, registered view; 0 when entry 0 is invalid.
- busy  out  1  scan/insert in progress.
- done  out  1  one-cycle pulse when an insertion attempt completes.
- rank  out  RANK_W  rank of the last attempt; DEPTH means "not placed". Held until the next done.
- new_record  out  1  one-cycle pulse coincident with done when rank==0.

## Operation
- **Reset:** all entries invalid with score 0; mode_q=0; state IDLE. Outputs busy=0, done=0, new_record=0, rank=DEPTH, highest_score=0.
- **Start condition:** mode==FINISH_MODE && mode_q!=FINISH_MODE, sampled at a rising edge. mode_q is registered every cycle regardless of state. Only one attempt per game occurs.
- **IDLE:**
  - On start: latch score into cand, set idx=0, set pos=DEPTH, go to SCAN.
  - Starts while not IDLE are dropped, and not queued.
- **SCAN (DEPTH cycles):** each cycle compares cand against entry idx.
  - The candidate beats the entry if the entry is invalid, or if cand > entry score.
  - On the first beat (pos==DEPTH), set pos=idx.
  - idx increments each cycle. After idx==DEPTH-1, go to INSERT.
  - The scan never terminates early.
- **INSERT (1 cycle):**
  - If pos<DEPTH: entries pos..DEPTH-2 move to pos+1..DEPTH-1, entry DEPTH-1 is discarded, and entry pos gets cand with valid=1.
  - Set rank=pos, pulse done, pulse new_record if pos==0, return to IDLE.
  - If pos==DEPTH, the table is unchanged and rank=DEPTH.
- **Ties:** equal scores do not beat an existing entry, so an older equal score ranks above the new one (default).
- **Arithmetic:** comparisons are unsigned, full SCORE_W. A score of 0 still qualifies for an invalid slot.
- **clear:**
  - Highest priority after rst. At the edge it is sampled, all entries become invalid/0 and state goes to IDLE.
  - An in-flight attempt is aborted with no done pulse; rank is reset to DEPTH.
  - A start on the same edge as clear is dropped.
- **rst mid-operation:** immediate return to the reset state; there is no done pulse.

## Timing
- Start sampled at edge k. busy=1 after edge k, through the cycle following edge k+DEPTH.
- SCAN compares occur at edges k+1 … k+DEPTH.
- INSERT completes at edge k+DEPTH+1. After that edge: table updated, highest_score updated, done=1 and new_record valid for exactly one cycle, busy=0.
- Latency is DEPTH+1 cycles from start edge to done; the default (DEPTH=4) gives 5.
- The earliest next start is at edge k+DEPTH+2, which requires mode to leave FINISH_MODE and re-enter it.
- The rd_* outputs reflect table contents combinationally and change on the INSERT edge.

## Configuration
- **HS_TIE_NEWER_FIRST_EN:**
  - Defined: cand >= entry score beats a valid entry, so a new equal score ranks above the older equal one.
  - Undefined (default): strict >, as above.
  - Latency and all other behaviour are identical.

## Test plan
- **Reset/empty:** assert rst mid-cycle → outputs clear immediately. highest_score=0, all rd_valid=0, rank=4, busy=0.
- **First fill:** enter FINISH with score=0 → done after 5 cycles, rank=0, new_record=1, entry0=0 valid.
- **Sorted insert:** load scores 50, 90, 70, 10 in separate games → table 90, 70, 50, 10. The 70 game reports rank=1 and new_record=0. Then score 60 → rank=2, table 90, 70, 60, 50.
- **Not placed / tie:**
  - Full table 90, 70, 60, 50 with score 50 → rank=4, table unchanged.
  - With HS_TIE_NEWER_FIRST_EN, the same score 50 → rank=3; entry3 becomes the new 50.
  - Score 255 → rank=0, new_record=1, highest_score=255.
- **Re-trigger:** hold mode=FINISH for 20 cycles → exactly one done. Toggle mode away and back during busy → second start ignored, single done.
- **Abort:**
  - Assert clear two cycles after start → no done, table empty, busy=0 next cycle.
  - Assert rst during SCAN → same result, asynchronously.
